// File: rtl/sif_buf.sv
// rtl/sif_buf.sv - posted-write FIFO to a ready/valid drain, plus a fixed-latency scrambled read path.
// Optional wa_par/xa_rd_par parity outputs are enabled by defining SIF_BUF_PARITY_EN.
module sif_buf #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          xa_wr_s,
  input  logic          xa_rd_s,
  input  logic [AW-1:0] xa_addr,
  input  logic [DW-1:0] xa_data_wr,
  output logic          xa_busy,
  output logic [AW-1:0] xa_data_rd,
  output logic          xa_rd_vld,
  output logic          wa_wr_s,
  input  logic          wa_rdy,
  output logic [AW-1:0] wa_addr,
  output logic [DW-1:0] wa_data_wr,
`ifdef SIF_BUF_PARITY_EN
  output logic          wa_par,
  output logic          xa_rd_par,
`endif
  output logic          wr_ovf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [AW-1:0] r_mem_addr [DEPTH];
  logic [DW-1:0] r_mem_data [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_wa_wr_s;
  logic [AW-1:0] r_wa_addr;
  logic [DW-1:0] r_wa_data;
  logic          r_wr_ovf;

  logic w_busy;
  logic w_push;
  logic w_pop;
  logic w_mem_empty;
  logic w_load;
  logic w_load_mem;
  logic w_bypass;
  logic w_mem_wr;

  // r_count covers both the memory and the output register, so the memory
  // holds r_count - r_wa_wr_s entries.
  assign w_busy      = (r_count == CW'(DEPTH));
  assign w_push      = xa_wr_s & ~w_busy;
  assign w_pop       = r_wa_wr_s & wa_rdy;
  assign w_mem_empty = (r_count == CW'(r_wa_wr_s));
  assign w_load      = ~r_wa_wr_s | w_pop;
  assign w_load_mem  = w_load & ~w_mem_empty;
  assign w_bypass    = w_load & w_mem_empty & w_push;
  assign w_mem_wr    = w_push & ~w_bypass;

`ifdef SIF_BUF_PARITY_EN
  logic r_mem_par [DEPTH];
  logic r_wa_par;
  logic w_in_par;
  assign w_in_par = ^{xa_addr, xa_data_wr};
`endif

  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      r_mem_addr[r_wptr] <= xa_addr;
      r_mem_data[r_wptr] <= xa_data_wr;
`ifdef SIF_BUF_PARITY_EN
      r_mem_par[r_wptr]  <= w_in_par;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_wa_wr_s <= 1'b0;
      r_wa_addr <= '0;
      r_wa_data <= '0;
      r_wr_ovf  <= 1'b0;
`ifdef SIF_BUF_PARITY_EN
      r_wa_par  <= 1'b0;
`endif
    end else begin
      if (w_mem_wr)   r_wptr <= r_wptr + 1'b1;
      if (w_load_mem) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (xa_wr_s && w_busy) r_wr_ovf <= 1'b1;
      // Memory head has priority; an empty memory lets the new write go straight out.
      if (w_load_mem) begin
        r_wa_wr_s <= 1'b1;
        r_wa_addr <= r_mem_addr[r_rptr];
        r_wa_data <= r_mem_data[r_rptr];
`ifdef SIF_BUF_PARITY_EN
        r_wa_par  <= r_mem_par[r_rptr];
`endif
      end else if (w_bypass) begin
        r_wa_wr_s <= 1'b1;
        r_wa_addr <= xa_addr;
        r_wa_data <= xa_data_wr;
`ifdef SIF_BUF_PARITY_EN
        r_wa_par  <= w_in_par;
`endif
      end else if (w_load) begin
        r_wa_wr_s <= 1'b0;
      end
    end
  end

  logic [AW-1:0] w_scr;
  logic [AW-1:0] r_rd_data [RD_LAT];
  logic          r_rd_vld  [RD_LAT];

  always_comb begin
    w_scr    = xa_addr;
    w_scr[8] = xa_addr[8] ^ xa_addr[4];
    w_scr[7] = xa_addr[7] ^ xa_addr[5];
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_rd_data[i] <= '0;
        r_rd_vld[i]  <= 1'b0;
      end
    end else begin
      r_rd_data[0] <= xa_rd_s ? w_scr : '0;
      r_rd_vld[0]  <= xa_rd_s;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_data[i] <= r_rd_data[i-1];
        r_rd_vld[i]  <= r_rd_vld[i-1];
      end
    end
  end

  assign xa_busy    = w_busy;
  assign xa_data_rd = r_rd_data[RD_LAT-1];
  assign xa_rd_vld  = r_rd_vld[RD_LAT-1];
  assign wa_wr_s    = r_wa_wr_s;
  assign wa_addr    = r_wa_addr;
  assign wa_data_wr = r_wa_data;
  assign wr_ovf     = r_wr_ovf;
`ifdef SIF_BUF_PARITY_EN
  assign wa_par     = r_wa_par;
  assign xa_rd_par  = ^r_rd_data[RD_LAT-1];
`endif

endmodule

// File: tb/tb_sif_buf.sv
// tb/tb_sif_buf.sv - directed self-checking bench for sif_buf (RD_LAT=1 and RD_LAT=3 instances).
module tb_sif_buf;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        xa_wr_s, xa_rd_s, wa_rdy;
  logic [15:0] xa_addr, xa_data_wr;
  logic        xa_busy, xa_rd_vld, wa_wr_s, wr_ovf;
  logic [15:0] xa_data_rd, wa_addr, wa_data_wr;
  logic        b_busy, b_rd_vld, b_wr_s, b_ovf;
  logic [15:0] b_data_rd, b_addr, b_data_wr;
`ifdef SIF_BUF_PARITY_EN
  logic        wa_par, xa_rd_par, b_wa_par, b_rd_par;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sif_buf #(.AW(16), .DW(16), .DEPTH(4), .RD_LAT(1)) dut (
    .clk(clk), .rst_b(rst_b), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s),
    .xa_addr(xa_addr), .xa_data_wr(xa_data_wr), .xa_busy(xa_busy),
    .xa_data_rd(xa_data_rd), .xa_rd_vld(xa_rd_vld), .wa_wr_s(wa_wr_s),
    .wa_rdy(wa_rdy), .wa_addr(wa_addr), .wa_data_wr(wa_data_wr),
`ifdef SIF_BUF_PARITY_EN
    .wa_par(wa_par), .xa_rd_par(xa_rd_par),
`endif
    .wr_ovf(wr_ovf));

  sif_buf #(.AW(16), .DW(16), .DEPTH(4), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_b(rst_b), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s),
    .xa_addr(xa_addr), .xa_data_wr(xa_data_wr), .xa_busy(b_busy),
    .xa_data_rd(b_data_rd), .xa_rd_vld(b_rd_vld), .wa_wr_s(b_wr_s),
    .wa_rdy(wa_rdy), .wa_addr(b_addr), .wa_data_wr(b_data_wr),
`ifdef SIF_BUF_PARITY_EN
    .wa_par(b_wa_par), .xa_rd_par(b_rd_par),
`endif
    .wr_ovf(b_ovf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wa(input string tag, input logic v, input logic [15:0] a, input logic [15:0] d);
    chk({tag, ".wr_s"}, {31'd0, wa_wr_s}, {31'd0, v});
    chk({tag, ".addr"}, {16'd0, wa_addr}, {16'd0, a});
    chk({tag, ".data"}, {16'd0, wa_data_wr}, {16'd0, d});
  endtask

  task automatic chk_rd(input string tag, input logic v, input logic [15:0] d);
    chk({tag, ".vld"}, {31'd0, xa_rd_vld}, {31'd0, v});
    chk({tag, ".data"}, {16'd0, xa_data_rd}, {16'd0, d});
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    xa_wr_s = 1'b1; xa_addr = a; xa_data_wr = d;
    tick();
    xa_wr_s = 1'b0;
  endtask

  logic [15:0] rd_a [3] = '{16'h05de, 16'h0463, 16'h1305};
  logic [15:0] rd_d [3] = '{16'h04de, 16'h04e3, 16'h1305};
  logic        t4_rdy [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [15:0] t4_a   [5] = '{16'h0202, 16'h0202, 16'h0203, 16'h0203, 16'h0203};
  logic        t4_v   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_b = 1'b0; xa_wr_s = 1'b0; xa_rd_s = 1'b0; wa_rdy = 1'b0;
    xa_addr = '0; xa_data_wr = '0;
    tick(); tick();
    chk_wa("rst", 1'b0, 16'h0, 16'h0);
    chk_rd("rst", 1'b0, 16'h0);
    chk("rst.busy", {31'd0, xa_busy}, 32'd0);
    chk("rst.ovf", {31'd0, wr_ovf}, 32'd0);
    rst_b = 1'b1;
    tick();

    // Scrambled reads, one per cycle
    for (int i = 0; i < 3; i++) begin
      xa_rd_s = 1'b1; xa_addr = rd_a[i];
      tick();
      chk_rd($sformatf("rd%0d", i), 1'b1, rd_d[i]);
    end
    xa_rd_s = 1'b0;
    tick();
    chk_rd("rd_idle", 1'b0, 16'h0);

    // Single write with ready high
    wa_rdy = 1'b1;
    wr(16'h0010, 16'habcd);
    chk_wa("w1", 1'b1, 16'h0010, 16'habcd);
    tick();
    chk_wa("w1_done", 1'b0, 16'h0010, 16'habcd);

    // Fill past full with ready low
    wa_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) wr(16'h0100 + 16'(i), 16'ha000 + 16'(i));
    chk("full.busy", {31'd0, xa_busy}, 32'd1);
    chk("full.ovf0", {31'd0, wr_ovf}, 32'd0);
    wr(16'h0105, 16'ha005);
    chk("full.ovf1", {31'd0, wr_ovf}, 32'd1);
    chk_wa("full.head", 1'b1, 16'h0101, 16'ha001);
    wa_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk_wa($sformatf("drain%0d", i), 1'b1, 16'h0100 + 16'(i), 16'ha000 + 16'(i));
      tick();
    end
    chk_wa("drain_end", 1'b0, 16'h0104, 16'ha004);
    chk("drain.busy", {31'd0, xa_busy}, 32'd0);
    chk("drain.ovf", {31'd0, wr_ovf}, 32'd1);

    // Stalls with ready toggling
    wa_rdy = 1'b0;
    for (int i = 1; i <= 3; i++) wr(16'h0200 + 16'(i), 16'hb000 + 16'(i));
    chk_wa("stall0", 1'b1, 16'h0201, 16'hb001);
    for (int i = 0; i < 5; i++) begin
      wa_rdy = t4_rdy[i];
      tick();
      chk_wa($sformatf("stall%0d", i + 1), t4_v[i], t4_a[i], 16'hb000 + (t4_a[i] & 16'h00ff));
    end

    // RD_LAT=3 read alongside a write
    wa_rdy = 1'b1;
    xa_rd_s = 1'b1; xa_addr = 16'h05de;
    xa_wr_s = 1'b1; xa_data_wr = 16'hc0de;
    tick();
    xa_rd_s = 1'b0; xa_wr_s = 1'b0;
    chk("lat3.n0", {15'd0, b_rd_vld, b_data_rd}, {15'd0, 1'b0, 16'h0});
    chk_rd("lat1.n0", 1'b1, 16'h04de);
    chk_wa("lat3.w", 1'b1, 16'h05de, 16'hc0de);
    tick();
    chk("lat3.n1", {15'd0, b_rd_vld, b_data_rd}, {15'd0, 1'b0, 16'h0});
    chk("lat3.wdone", {31'd0, b_wr_s}, 32'd0);
    tick();
    chk("lat3.n2", {15'd0, b_rd_vld, b_data_rd}, {15'd0, 1'b1, 16'h04de});
    tick();
    chk("lat3.n3", {15'd0, b_rd_vld, b_data_rd}, {15'd0, 1'b0, 16'h0});

    // Reset mid-operation
    wa_rdy = 1'b0;
    wr(16'h0401, 16'hd001);
    xa_rd_s = 1'b1; xa_addr = 16'h0463;
    wr(16'h0402, 16'hd002);
    xa_rd_s = 1'b0;
    rst_b = 1'b0;
    #1;
    chk_wa("mrst", 1'b0, 16'h0, 16'h0);
    chk_rd("mrst", 1'b0, 16'h0);
    chk("mrst.b_rd", {15'd0, b_rd_vld, b_data_rd}, 32'd0);
    chk("mrst.ovf", {31'd0, wr_ovf}, 32'd0);
    wa_rdy = 1'b1;
    tick();
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mrst.nopulse%0d", i), {30'd0, wa_wr_s, b_rd_vld}, 32'd0);
    end
    wa_rdy = 1'b0;
    for (int i = 1; i <= 3; i++) wr(16'h0500 + 16'(i), 16'he000 + 16'(i));
    chk("mrst.cnt3", {31'd0, xa_busy}, 32'd0);
    wr(16'h0504, 16'he004);
    chk("mrst.cnt4", {31'd0, xa_busy}, 32'd1);
    chk_wa("mrst.head", 1'b1, 16'h0501, 16'he001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sif_buf.md
Name: sif_buf

Overview:
- Parametrised second-generation small training interface.
- Writes from the xa side are posted into a DEPTH-entry FIFO and drained to the wa side under a ready/valid handshake, with backpressure and overflow reporting.
- Reads return the address with bits scrambled, after a configurable pipeline latency, and carry a valid strobe.
- Sits between a training master and a downstream write target.

Parameters:
- AW, 16, address width and read-data width; must be >= 9.
- DW, 16, write data width.
- DEPTH, 4, write FIFO entries; power of 2, >= 2.
- RD_LAT, 1, read latency in clocks; >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_b  input  1  reset; asynchronous, active-low.
- xa_wr_s  input  1  write request.
- xa_rd_s  input  1  read request.
- xa_addr  input  AW  address for the read or write.
- xa_data_wr  input  DW  write data.
- xa_busy  output  1  FIFO full; writes are not accepted this cycle.
- xa_data_rd  output  AW  read result.
- xa_rd_vld  output  1  xa_data_rd is valid this cycle.
- wa_wr_s  output  1  downstream write valid.
- wa_rdy  input  1  downstream ready.
- wa_addr  output  AW  downstream write address.
- wa_data_wr  output  DW  downstream write data.
- wr_ovf  output  1  sticky overflow flag.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0, the FIFO is empty, and the read pipeline is cleared.
  - Reset mid-operation discards pending FIFO entries and in-flight reads; no wa_wr_s pulse is emitted for them.
- Write accept: a write is accepted on a rising edge where xa_wr_s=1 and xa_busy=0.
- Write rejected when full: xa_wr_s=1 while xa_busy=1 drops the write and sets wr_ovf=1 from the next cycle. wr_ovf is cleared only by reset.
- xa_busy:
  - Equals (count==DEPTH), derived from registered count.
  - A pop in the same cycle does not make room for a push in that cycle.
- Drain:
  - wa_wr_s, wa_addr and wa_data_wr are registers holding the FIFO head entry.
  - A transfer completes on an edge with wa_wr_s=1 and wa_rdy=1.
  - While wa_wr_s=1 and wa_rdy=0, wa_addr and wa_data_wr hold stable.
  - After the final transfer, wa_wr_s drops to 0 and wa_addr/wa_data_wr keep their last values.
- Latency:
  - A write accepted at edge N into an empty FIFO gives wa_wr_s=1 in cycle N+1.
  - Back-to-back writes with wa_rdy held at 1 give back-to-back transfers, one per cycle.
- Ordering: strict FIFO order. Simultaneous push and pop keeps count unchanged. Pointers wrap modulo DEPTH.
- Read scramble:
  - d[AW-1:9] = a[AW-1:9]
  - d[8] = a[8]^a[4]
  - d[7] = a[7]^a[5]
  - d[6:0] = a[6:0]
- Read pipeline:
  - A read sampled at edge N presents d and xa_rd_vld=1 after edge N+RD_LAT-1, i.e. visible in the cycle after edge N when RD_LAT=1.
  - Cycles with no read present xa_data_rd=0 and xa_rd_vld=0.
  - The pipeline is fully pipelined: one read per cycle.
- Concurrency:
  - Reads and writes are independent; xa_rd_s and xa_wr_s may both be high in the same cycle.
  - Reads ignore xa_busy and FIFO contents.

Optional Feature:
- Macro: SIF_BUF_PARITY_EN.
- Defined:
  - Adds output wa_par (1), the even parity of {wa_addr, wa_data_wr}, stored with each FIFO entry.
  - Adds output xa_rd_par (1), the even parity of xa_data_rd, aligned with xa_rd_vld.
  - Both reset to 0.
- Undefined: the ports and parity storage are absent, and all other behaviour is identical.

Test Plan:
- Reads with RD_LAT=1, one per cycle, addresses 05de, 0463, 1305 -> xa_data_rd 04de, 04e3, 1305 on consecutive cycles, each with xa_rd_vld=1; 0 and vld=0 afterwards.
- wa_rdy=1, write addr 0010 data abcd -> next cycle wa_wr_s=1, wa_addr=0010, wa_data_wr=abcd; then wa_wr_s=0 with values held.
- wa_rdy=0, 5 writes with DEPTH=4 -> xa_busy=1 after the 4th, the 5th is dropped and wr_ovf=1; raising wa_rdy drains exactly entries 1-4 in order.
- wa_rdy toggling 1,0,1,0 with 3 queued writes -> wa_addr/wa_data_wr stable while stalled, no duplicates, order preserved.
- RD_LAT=3, read 05de at edge N together with a write -> 04de visible after edge N+2 with xa_rd_vld=1; the write drains independently.
- rst_b low with 2 FIFO entries and a read in flight -> all outputs 0, no wa_wr_s pulse after release, wr_ovf=0, count=0.
